tx_framer: RTL

TX_FRAMER -- requirements
Module: tx_framer

---
 rtl/tx_pkg.sv | 20 ++
 rtl/tx_bit_strobe.sv | 27 ++
 rtl/tx_framer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/tx_pkg.sv
// Shared types and constants for the serial frame transmitter.
// The PARITY state exists only when TX_FRAMER_PARITY_EN is defined.
package tx_pkg;

  localparam logic [7:0] SYNC_WORD_DEF    = 8'hE8;
  localparam int         BIT_DIV_DEF      = 16;
  localparam int         PREAMBLE_LEN_DEF = 8;
  localparam logic       RST_ACTIVE       = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SYNC,
    ST_PAYLOAD
`ifdef TX_FRAMER_PARITY_EN
    , ST_PARITY
`endif
  } tx_state_e;

endpackage

// File: rtl/tx_bit_strobe.sv
// Free-running bit-period divider: strobe is high for one clk cycle
// out of every BIT_DIV, marking the last cycle of each bit slot.
module tx_bit_strobe
  import tx_pkg::*;
#(
  parameter int BIT_DIV = BIT_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic strobe
);

  localparam int CW = $clog2(BIT_DIV);

  logic [CW-1:0] cnt;

  assign strobe = (cnt == CW'(BIT_DIV - 1));

  // NOTE: clocked state uses non-blocking assignments only, so every
  // always_ff reads the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) cnt <= '0;
    else if (strobe)       cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/tx_framer.sv
// Serial frame transmitter: preamble, sync word, FRAME_BYTES payload bytes.
// Define TX_FRAMER_PARITY_EN to follow every payload byte with an even-parity bit.
module tx_framer
  import tx_pkg::*;
#(
  parameter int         BIT_DIV      = BIT_DIV_DEF,
  parameter int         FRAME_BYTES  = 4,
  parameter int         PREAMBLE_LEN = PREAMBLE_LEN_DEF,
  parameter logic [7:0] SYNC_WORD    = SYNC_WORD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_i,
  input  logic       byte_valid_i,
  output logic       byte_ready_o,
  output logic       data_o,
  output logic       busy_o,
  output logic       frame_done_o,
  output logic       underrun_o
);

  tx_state_e  state, state_nxt;
  logic [4:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] byte_cnt, byte_cnt_nxt;
  logic [7:0] shift_q, hold_data;
  logic       data_q, data_nxt;
  logic       hold_full, rst_done;
  logic       strobe, boundary, load, accept, last_byte;

  tx_bit_strobe #(.BIT_DIV(BIT_DIV)) u_strobe (
    .clk    (clk),
    .rst    (rst),
    .strobe (strobe)
  );

  assign accept    = byte_valid_i & byte_ready_o;
  assign last_byte = (byte_cnt == 8'(FRAME_BYTES - 1));
  assign data_o    = data_q;

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      shift_q   <= '0;
      data_q    <= 1'b0;
      hold_full <= 1'b0;
      rst_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      byte_cnt  <= byte_cnt_nxt;
      data_q    <= data_nxt;
      rst_done  <= 1'b1;
      if (load)        shift_q   <= hold_data;
      if (load)        hold_full <= 1'b0;
      else if (accept) hold_full <= 1'b1;
    end
  end

  // NOTE: the payload byte itself needs no reset; hold_full alone says
  // whether it is meaningful.
  always_ff @(posedge clk) begin
    if (accept) hold_data <= byte_i;
  end

  // NOTE: every signal gets a default before the case so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    byte_cnt_nxt = byte_cnt;
    data_nxt     = data_q;
    boundary     = 1'b0;
    load         = 1'b0;
    if (strobe) begin
      unique case (state)
        ST_IDLE: begin
          data_nxt = hold_full;
          if (hold_full) begin
            state_nxt   = ST_PREAMBLE;
            bit_cnt_nxt = '0;
          end
        end
        ST_PREAMBLE: begin
          if (bit_cnt == 5'(PREAMBLE_LEN - 1)) begin
            state_nxt   = ST_SYNC;
            bit_cnt_nxt = '0;
            data_nxt    = SYNC_WORD[7];
          end else begin
            bit_cnt_nxt = bit_cnt + 5'd1;
            data_nxt    = bit_cnt[0];
          end
        end
        ST_SYNC: begin
          if (bit_cnt == 5'd7) begin
            boundary = 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt + 5'd1;
            data_nxt    = SYNC_WORD[3'(3'd6 - bit_cnt[2:0])];
          end
        end
        ST_PAYLOAD: begin
          if (bit_cnt == 5'd7) begin
`ifdef TX_FRAMER_PARITY_EN
            state_nxt = ST_PARITY;
            data_nxt  = ^shift_q;
`else
            boundary  = 1'b1;
`endif
          end else begin
            bit_cnt_nxt = bit_cnt + 5'd1;
            data_nxt    = shift_q[3'(3'd6 - bit_cnt[2:0])];
          end
        end
`ifdef TX_FRAMER_PARITY_EN
        ST_PARITY: boundary = 1'b1;
`endif
        default: begin
          state_nxt = ST_IDLE;
          data_nxt  = 1'b0;
        end
      endcase

      // Byte boundary: finish the frame, take the next byte, or abort.
      if (boundary) begin
        bit_cnt_nxt = '0;
        if (state != ST_SYNC && last_byte) begin
          state_nxt = hold_full ? ST_PREAMBLE : ST_IDLE;
          data_nxt  = hold_full;
        end else if (hold_full) begin
          load         = 1'b1;
          state_nxt    = ST_PAYLOAD;
          data_nxt     = hold_data[7];
          byte_cnt_nxt = (state == ST_SYNC) ? 8'd0 : byte_cnt + 8'd1;
        end else begin
          state_nxt = ST_IDLE;
          data_nxt  = 1'b0;
        end
      end
    end
  end

  always_comb begin
    busy_o       = (state != ST_IDLE);
    byte_ready_o = rst_done & ~hold_full;
    frame_done_o = 1'b0;
    underrun_o   = 1'b0;
    // Pulses are suppressed while reset is asserted so an aborted frame reports nothing.
    if (rst != RST_ACTIVE && boundary) begin
      if (state != ST_SYNC && last_byte) frame_done_o = 1'b1;
      else if (!hold_full)               underrun_o   = 1'b1;
    end
  end

endmodule
